// File: rtl/lsu_ctrl.sv
// Load/store controller in front of the data memory: buffers in-order requests in a
// small FIFO, runs one memory access at a time and returns a response per request.
module lsu_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int MEM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  MEM_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  logic              fifo_we_q    [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  state_e            state_q, state_d;
  logic              op_we_q, op_we_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_we_n_q, mem_we_n_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              empty, full, push, pop;
  logic              head_we, head_oor;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_FULL);
  assign push       = req_valid && !full;
  assign pop        = (state_q == IDLE) && !empty;
  assign head_we    = fifo_we_q[rd_ptr_q];
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_wdata = fifo_wdata_q[rd_ptr_q];
  assign head_oor   = ({1'b0, head_addr} >= MEM_LIMIT);

  // NOTE: FIFO storage carries no reset; entries are only read once count says they hold data.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]    <= req_we;
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_wdata_q[wr_ptr_q] <= req_wdata;
    end
  end

  always_comb begin
    // NOTE: every next-state value starts from its current value so no path infers a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    op_we_d      = op_we_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we_n_d   = mem_we_n_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          op_we_d = head_we;
          if (head_oor) begin
            // Trapped before the memory: the memory port keeps its previous values.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            mem_addr_d  = head_addr;
            mem_wdata_d = head_wdata;
            mem_we_n_d  = !head_we;
          end
        end
      end
      ISSUE: begin
        mem_we_n_d = 1'b1;
        if (op_we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = mem_rdata;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Async reset pulls mem_we_n high at once, aborting a store caught in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      op_we_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_we_n_q   <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      op_we_q      <= op_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_we_n_q   <= mem_we_n_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = !full;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_we_n   = mem_we_n_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl paired with a 1024x16 registered-read memory whose power-up word i = i.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [15:0] resp_rdata;
  logic        mem_we_n;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int we_low_cnt = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_pulses;
  } vec_t;

  vec_t        vecs [10];
  vec_t        sq [$];
  logic [16:0] got [$];

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we_n   (mem_we_n),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // Data memory model: words never written read back as their own address.
  logic [15:0]   mem_words [1024];
  logic [1023:0] written = '0;

  always @(posedge clk) begin
    if (!mem_we_n) begin
      mem_words[mem_addr[9:0]] <= mem_wdata;
      written[mem_addr[9:0]]   <= 1'b1;
    end
    mem_rdata <= written[mem_addr[9:0]] ? mem_words[mem_addr[9:0]] : {6'b0, mem_addr[9:0]};
  end

  always @(negedge clk) begin
    if (rst_n && !mem_we_n) we_low_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},  {31'b0, req_ready},  32'd1);
    check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, " resp_rdata"}, {16'b0, resp_rdata}, 32'd0);
    check({tag, " resp_err"},   {31'b0, resp_err},   32'd0);
    check({tag, " mem_we_n"},   {31'b0, mem_we_n},   32'd1);
    check({tag, " mem_addr"},   {16'b0, mem_addr},   32'd0);
    check({tag, " mem_wdata"},  {16'b0, mem_wdata},  32'd0);
    check({tag, " busy"},       {31'b0, busy},       32'd0);
  endtask

  // One request into an idle controller; latency counted in edges after acceptance.
  task automatic run_op(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    we_low_cnt = 0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  // Pushes sq back-to-back; resp_ready held low for the first `hold` cycles.
  task automatic stream(input int hold, output int acc_hold, output logic rdy_hold);
    int acc;
    int n;
    acc = 0;
    n = sq.size();
    got.delete();
    acc_hold = 0;
    rdy_hold = 1'b1;
    for (int cyc = 0; cyc < 300 && got.size() < n; cyc++) begin
      @(negedge clk);
      resp_ready = (cyc >= hold);
      if (cyc == hold) begin
        acc_hold = acc;
        rdy_hold = req_ready;
      end
      if (acc < n) begin
        req_valid = 1'b1;
        req_we    = sq[acc].we;
        req_addr  = sq[acc].addr;
        req_wdata = sq[acc].wdata;
      end else begin
        req_valid = 1'b0;
      end
      if (req_valid && req_ready) acc++;
      if (resp_valid && resp_ready) got.push_back({resp_err, resp_rdata});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    check({tag, " count"}, got.size(), sq.size());
    for (int i = 0; i < got.size() && i < sq.size(); i++)
      check($sformatf("%s resp%0d", tag, i), {15'b0, got[i]}, {15'b0, sq[i].exp_err, sq[i].exp_rdata});
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          acc_hold;
    logic        rdy_hold;

    vecs[0] = '{1'b0, 16'd5,    16'h0000, 16'd5,    1'b0, 3, 0};
    vecs[1] = '{1'b1, 16'd10,   16'hBEEF, 16'h0000, 1'b0, 2, 1};
    vecs[2] = '{1'b0, 16'd10,   16'h0000, 16'hBEEF, 1'b0, 3, 0};
    vecs[3] = '{1'b0, 16'd1024, 16'h0000, 16'h0000, 1'b1, 1, 0};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h1111, 16'h0000, 1'b1, 1, 0};
    vecs[5] = '{1'b0, 16'd1023, 16'h0000, 16'd1023, 1'b0, 3, 0};
    vecs[6] = '{1'b0, 16'd0,    16'h0000, 16'd0,    1'b0, 3, 0};
    vecs[7] = '{1'b1, 16'd1023, 16'hABCD, 16'h0000, 1'b0, 2, 1};
    vecs[8] = '{1'b0, 16'd1023, 16'h0000, 16'hABCD, 1'b0, 3, 0};
    vecs[9] = '{1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1, 0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d rdata", i), {16'b0, rd}, {16'b0, vecs[i].exp_rdata});
      check($sformatf("v%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d we_pulses", i), we_low_cnt, vecs[i].exp_pulses);
    end

    // Backpressure: 4 in the FIFO plus 1 parked in RESP, then an in-order drain.
    sq.delete();
    for (int i = 0; i < 8; i++) sq.push_back('{1'b0, 16'(i), 16'h0, 16'(i), 1'b0, 0, 0});
    stream(12, acc_hold, rdy_hold);
    check("bp accepts_while_stalled", acc_hold, 5);
    check("bp req_ready_while_full", {31'b0, rdy_hold}, 32'd0);
    check_stream("bp");
    check("bp busy_after_drain", {31'b0, busy}, 32'd0);

    // One push per cycle with mixed loads, an error, and a store/load pair.
    sq.delete();
    for (int i = 0; i < 5; i++) sq.push_back('{1'b0, 16'(100 + i), 16'h0, 16'(100 + i), 1'b0, 0, 0});
    sq.push_back('{1'b0, 16'd2000, 16'h0000, 16'h0000, 1'b1, 0, 0});
    sq.push_back('{1'b1, 16'd200,  16'h5555, 16'h0000, 1'b0, 0, 0});
    sq.push_back('{1'b0, 16'd200,  16'h0000, 16'h5555, 1'b0, 0, 0});
    sq.push_back('{1'b0, 16'd106,  16'h0000, 16'd106,  1'b0, 0, 0});
    stream(0, acc_hold, rdy_hold);
    check_stream("pp");

    // Reset while a store sits in ISSUE: the write must never reach the memory.
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 16'd20;
    req_wdata  = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst issue mem_we_n", {31'b0, mem_we_n}, 32'd0);
    check("rst issue mem_addr", {16'b0, mem_addr}, 32'd20);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_store");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 16'd20, 16'h0, rd, er, lat);
    check("rst reload latency", lat, 3);
    check("rst reload rdata", {16'b0, rd}, 32'd20);
    check("rst reload err", {31'b0, er}, 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
